// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: tile codes, maze geometry, score and pellet types,
// and the built-in maze images that stand in for the .mem tile maps.
package pacman_pkg;

  localparam logic [7:0] TILE_EMPTY = 8'h00;
  localparam logic [7:0] TILE_WALL  = 8'h01;
  localparam logic [7:0] TILE_DOT   = 8'h02;
  localparam logic [7:0] TILE_POWER = 8'h03;
  localparam logic [7:0] TILE_GATE  = 8'h04;

  localparam int TILE_WIDTH  = 16;
  localparam int TILE_HEIGHT = 16;
  localparam int MAZE_ROWS   = 30;
  localparam int MAZE_COLS   = 40;

  // Digit [3] is thousands, digit [0] is ones.
  typedef logic [3:0][3:0] bcd4_t;

  localparam logic [3:0] PELLET_RED   = 4'hF;
  localparam logic [3:0] PELLET_GREEN = 4'hB;
  localparam logic [3:0] PELLET_BLUE  = 4'h8;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLEAR} pellet_state_e;

  function automatic logic is_edible(input logic [7:0] code);
    return (code == TILE_DOT) || (code == TILE_POWER);
  endfunction

  // Constant-evaluated tile images: "maze2.mem" is the walled play field with
  // pillar grid and four power pellets; "maze_two.mem" holds just two dots.
  function automatic logic [7:0] maze_tile(input bit two_dot, input int row, input int col,
                                           input int rows, input int cols);
    if (two_dot)
      return (row == 1 && (col == 1 || col == 2)) ? TILE_DOT : TILE_EMPTY;
    if (row == 0 || row == rows - 1 || col == 0 || col == cols - 1)
      return TILE_WALL;
    if ((row == 1 || row == rows - 2) && (col == 3 || col == cols - 4))
      return TILE_POWER;
    if (row % 2 == 0 && col % 2 == 0)
      return TILE_WALL;
    return TILE_DOT;
  endfunction

endpackage

// File: rtl/bcd_score_add.sv
// Combinational 4-digit BCD adder: adds a 0..9 increment to the tens digit,
// ripples the carry upward and saturates at 9999.
module bcd_score_add
  import pacman_pkg::*;
(
  input  bcd4_t      i_score,
  input  logic [3:0] i_tens_inc,
  output bcd4_t      o_sum
);

  logic [4:0] w_tens, w_hund, w_thou;
  logic       w_c_tens, w_c_hund, w_c_thou;

  // NOTE: every combinational output is assigned first, before any branch, so no latch is inferred.
  always_comb begin
    w_tens   = {1'b0, i_score[1]} + {1'b0, i_tens_inc};
    w_c_tens = (w_tens > 5'd9);
    if (w_c_tens) w_tens = w_tens - 5'd10;

    w_hund   = {1'b0, i_score[2]} + {4'd0, w_c_tens};
    w_c_hund = (w_hund > 5'd9);
    if (w_c_hund) w_hund = w_hund - 5'd10;

    w_thou   = {1'b0, i_score[3]} + {4'd0, w_c_hund};
    w_c_thou = (w_thou > 5'd9);

    o_sum = {w_thou[3:0], w_hund[3:0], w_tens[3:0], i_score[0]};
    if (w_c_thou) o_sum = 16'h9999;
  end

endmodule

// File: rtl/pellet_tracker.sv
// Pellet bookkeeping behind the movement stage: eats the tile under Pac-Man,
// keeps score and remaining count, and answers per-pixel pellet queries.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int    ROWS         = MAZE_ROWS,
  parameter int    COLS         = MAZE_COLS,
  parameter int    TILE         = TILE_WIDTH,
  parameter int    DOT_POINTS   = 10,
  parameter int    POWER_POINTS = 50,
  parameter string MAZE_FILE    = "maze2.mem"
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [9:0]  PacmanX,
  input  logic [9:0]  PacmanY,
  input  logic        game_over,
  input  logic [9:0]  vga_x,
  input  logic [9:0]  vga_y,
  output logic [15:0] score_bcd,
  output logic [10:0] dots_left,
  output logic        power_pulse,
  output logic        level_clear,
  output logic        busy,
  output logic [3:0]  pellet_red,
  output logic [3:0]  pellet_green,
  output logic [3:0]  pellet_blue
);

  localparam int         SHIFT       = $clog2(TILE);
  localparam int         ROW_W       = $clog2(ROWS);
  localparam int         COL_W       = $clog2(COLS);
  localparam bit         TWO_DOT     = (MAZE_FILE == "maze_two.mem");
  localparam logic [3:0] DOT_TENS    = 4'(DOT_POINTS / 10);
  localparam logic [3:0] POWER_TENS  = 4'(POWER_POINTS / 10);

  logic [7:0] w_tile [ROWS][COLS];
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign w_tile[r][c] = maze_tile(TWO_DOT, r, c, ROWS, COLS);
    end
  end

  pellet_state_e    r_state, w_next_state;
  logic [ROW_W-1:0] r_row;
  logic [COLS-1:0]  r_eaten [ROWS];
  logic [10:0]      r_dots_left, w_row_pop, w_init_sum;
  bcd4_t            r_score, w_score_next;
  logic             r_power_pulse;

  logic [9:0]       w_prow_full, w_pcol_full;
  logic             w_p_in_range, w_p_present, w_p_power, w_eat;
  logic [ROW_W-1:0] w_prow;
  logic [COL_W-1:0] w_pcol;
  logic [7:0]       w_p_code;

  assign w_prow_full  = PacmanY >> SHIFT;
  assign w_pcol_full  = PacmanX >> SHIFT;
  assign w_p_in_range = (w_prow_full < 10'(ROWS)) && (w_pcol_full < 10'(COLS));
  assign w_prow       = w_p_in_range ? w_prow_full[ROW_W-1:0] : '0;
  assign w_pcol       = w_p_in_range ? w_pcol_full[COL_W-1:0] : '0;
  assign w_p_code     = w_tile[w_prow][w_pcol];
  assign w_p_present  = w_p_in_range && is_edible(w_p_code) && !r_eaten[w_prow][w_pcol];
  assign w_p_power    = (w_p_code == TILE_POWER);
  assign w_eat        = (r_state == ST_RUN) && w_p_present && !game_over;

  bcd_score_add u_score_add (
    .i_score    (r_score),
    .i_tens_inc (w_p_power ? POWER_TENS : DOT_TENS),
    .o_sum      (w_score_next)
  );

  always_comb begin
    w_row_pop = '0;
    for (int c = 0; c < COLS; c++)
      w_row_pop = w_row_pop + 11'(is_edible(w_tile[r_row][c]));
    w_init_sum = r_dots_left + w_row_pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) r_state <= ST_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_INIT:  if (r_row == ROW_W'(ROWS - 1))
                  w_next_state = (w_init_sum == 11'd0) ? ST_CLEAR : ST_RUN;
      ST_RUN:   if (w_eat && r_dots_left == 11'd1) w_next_state = ST_CLEAR;
      ST_CLEAR: w_next_state = ST_CLEAR;
      default:  w_next_state = ST_INIT;
    endcase
  end

  always_comb begin
    busy        = (r_state == ST_INIT);
    level_clear = (r_state == ST_CLEAR);
  end

  // NOTE: the eaten map is a plain flop array, not a RAM, so it is cleared in one reset cycle.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_row         <= '0;
      r_dots_left   <= '0;
      r_score       <= '0;
      r_power_pulse <= 1'b0;
      for (int r = 0; r < ROWS; r++) r_eaten[r] <= '0;
    end else begin
      r_power_pulse <= 1'b0;
      if (r_state == ST_INIT) begin
        r_dots_left <= w_init_sum;
        r_row       <= r_row + ROW_W'(1);
      end else if (w_eat) begin
        r_eaten[w_prow][w_pcol] <= 1'b1;
        r_dots_left             <= r_dots_left - 11'd1;
        r_score                 <= w_score_next;
        r_power_pulse           <= w_p_power;
      end
    end
  end

  assign score_bcd   = r_score;
  assign dots_left   = r_dots_left;
  assign power_pulse = r_power_pulse;

  // Pixel path: pellets are drawn from the live eaten map, including during the init sweep.
  logic [9:0]       w_vrow_full, w_vcol_full, w_lx, w_ly;
  logic             w_v_in_range, w_v_present, w_dot_win, w_pow_win, w_pix_on;
  logic [ROW_W-1:0] w_vrow;
  logic [COL_W-1:0] w_vcol;
  logic [7:0]       w_v_code;

  assign w_vrow_full  = vga_y >> SHIFT;
  assign w_vcol_full  = vga_x >> SHIFT;
  assign w_lx         = vga_x & 10'(TILE - 1);
  assign w_ly         = vga_y & 10'(TILE - 1);
  assign w_v_in_range = (w_vrow_full < 10'(ROWS)) && (w_vcol_full < 10'(COLS));
  assign w_vrow       = w_v_in_range ? w_vrow_full[ROW_W-1:0] : '0;
  assign w_vcol       = w_v_in_range ? w_vcol_full[COL_W-1:0] : '0;
  assign w_v_code     = w_tile[w_vrow][w_vcol];
  assign w_v_present  = w_v_in_range && !r_eaten[w_vrow][w_vcol];
  assign w_dot_win    = (w_lx >= 10'd7) && (w_lx <= 10'd8) && (w_ly >= 10'd7) && (w_ly <= 10'd8);
  assign w_pow_win    = (w_lx >= 10'd5) && (w_lx <= 10'd10) && (w_ly >= 10'd5) && (w_ly <= 10'd10);
  assign w_pix_on     = w_v_present && (((w_v_code == TILE_DOT) && w_dot_win) ||
                                        ((w_v_code == TILE_POWER) && w_pow_win));

  assign pellet_red   = w_pix_on ? PELLET_RED   : 4'h0;
  assign pellet_green = w_pix_on ? PELLET_GREEN : 4'h0;
  assign pellet_blue  = w_pix_on ? PELLET_BLUE  : 4'h0;

endmodule
